shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Upstream sequencer for the 8-bit combinational logical-right barrel shifter (zero fill, 3-bit shift control, max 7 per pass).
- Accepts requests of {data word, shift amount 0..31} over a valid/ready handshake.
- Splits the amount into passes of at most 7 and loops the shifter result back through its own data register.
- Returns the final word over a valid/ready response handshake.
- Drives the shifter's data and control inputs and consumes its output in the same cycle.

Parameters:
DATA_W, 8, data word width; must match shifter width
CTRL_W, 3, shifter control width; MAX_STEP = 2**CTRL_W - 1 = 7
AMT_W, 5, request shift-amount width (0..31)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at a clk edge
req_data  in  DATA_W  word to shift
req_amt  in  AMT_W  total right-shift amount
sh_in  out  DATA_W  to shifter data input
sh_ctrl  out  CTRL_W  to shifter control input
sh_out  in  DATA_W  from shifter output (combinational from sh_in/sh_ctrl)
rsp_valid  out  1  result available
rsp_ready  in  1  result consumed when rsp_valid & rsp_ready at a clk edge
rsp_data  out  DATA_W  shifted result
busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. This is fixed.
- Registers: state {IDLE, SHIFT, DONE}, data_q[DATA_W], rem_q[AMT_W].
- Reset: state=IDLE, data_q=0, rem_q=0. Outputs after reset: rsp_valid=0, rsp_data=0, sh_ctrl=0, sh_in=0, busy=0. req_ready=0 while rst is high.
- Datapath: sh_in = data_q always. sh_ctrl = step only in SHIFT, else 0. step = min(rem_q, MAX_STEP). rsp_data = data_q.
- IDLE: req_ready=1. On accept, data_q<=req_data and rem_q<=req_amt. Next state is DONE if req_amt==0, else SHIFT.
- SHIFT: each edge, data_q<=sh_out and rem_q<=rem_q-step. When rem_q-step==0, go to DONE. req_ready=0.
- DONE: rsp_valid=1. data_q is held stable until the response handshake. req_ready = rsp_ready.
  - On the response handshake, if req_valid is high in the same cycle, the new request is accepted and loaded. Next state follows the IDLE rule (back-to-back, no bubble).
  - Otherwise, go to IDLE.
- Latency: rsp_valid rises ceil(req_amt/7) edges after the accept edge, or 1 edge when amt==0. Pass sequence: 7,7,...,remainder. Example: amt 31 gives passes 7,7,7,7,3 (5 passes).
- Backpressure: rsp_valid and rsp_data stay stable indefinitely while rsp_ready=0. No new request is accepted.
- Reset mid-operation: the operation is aborted. State returns to IDLE on the next edge and no response is emitted.
- Widths: rem_q subtraction never underflows because step ≤ rem_q.

Optional Feature:
Macro SHIFT_SEQ_SATURATE_EN.
- Defined: on accept with req_amt ≥ DATA_W, data_q<=0 and state goes directly to DONE (1-edge latency). The shifter is not exercised; sh_ctrl stays 0.
- Undefined: every amount iterates through SHIFT passes as above. The result is identical; only latency differs.

Decomposition:
- Package shift_seq_pkg holds:
  - DATA_W, CTRL_W, AMT_W, MAX_STEP constants;
  - state enum typedef seq_state_t {IDLE, SHIFT, DONE}.
- One natural sub-module: shift_step_calc. It is combinational, rem_q -> step = min(rem_q, MAX_STEP), and also outputs a last_pass flag (rem_q ≤ MAX_STEP).
- The barrel shifter is instantiated beside this block by the parent, not inside it.

Test Plan:
1. req_data=0xB6, amt=3 -> one pass with sh_ctrl=3; rsp_valid 1 edge after accept; rsp_data=0x16.
2. req_data=0x80, amt=7 -> rsp_data=0x01 after 1 edge. Then amt=9 -> sh_ctrl 7 then 2; rsp_data=0x00 after 2 edges.
3. req_data=0x5A, amt=0 -> no SHIFT cycles; sh_ctrl stays 0; rsp_data=0x5A, rsp_valid 1 edge after accept.
4. Response ready low for 4 cycles -> rsp_valid=1 and rsp_data held, req_ready=0. Then rsp_ready=1 together with req_valid=1 (0xF0, amt 4) -> both handshakes on the same edge; next rsp_data=0x0F.
5. amt=31 on 0xFF; rst=1 during the 3rd pass -> next edge state=IDLE, rsp_valid=0, busy=0, no response. A following request (0x11, amt 1) completes normally with 0x08.
6. With SHIFT_SEQ_SATURATE_EN, amt=20 on 0xFF -> rsp_data=0x00, rsp_valid 1 edge after accept, sh_ctrl never nonzero. Without the macro -> 3 passes (7,7,6), same result.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the shift sequencer.
// Optional feature macro: SHIFT_SEQ_SATURATE_EN (early-out for amounts >= DATA_W).
package shift_seq_pkg;

    localparam int DATA_W   = 8;
    localparam int CTRL_W   = 3;
    localparam int AMT_W    = 5;
    localparam int MAX_STEP = (2 ** CTRL_W) - 1;

    localparam logic [AMT_W-1:0]  MAX_STEP_AMT  = AMT_W'(MAX_STEP);
    localparam logic [CTRL_W-1:0] MAX_STEP_CTRL = CTRL_W'(MAX_STEP);
    localparam logic [AMT_W-1:0]  DATA_W_AMT    = AMT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_seq_ctrl_step_calc.sv
// Per-pass shift amount: min(remaining, MAX_STEP), plus a last-pass flag.
module shift_step_calc
    import shift_seq_pkg::*;
(
    input  logic [AMT_W-1:0]  rem,
    output logic [CTRL_W-1:0] step,
    output logic              last_pass
);

    always_comb begin
        last_pass = (rem <= MAX_STEP_AMT);
        step      = last_pass ? rem[CTRL_W-1:0] : MAX_STEP_CTRL;
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that loops a word through an external 7-max barrel shifter.
// Optional feature macro: SHIFT_SEQ_SATURATE_EN (amt >= DATA_W resolves in one edge).
module shift_seq_ctrl
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [AMT_W-1:0]  req_amt,
    output logic [DATA_W-1:0] sh_in,
    output logic [CTRL_W-1:0] sh_ctrl,
    input  logic [DATA_W-1:0] sh_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic [CTRL_W-1:0] step;
    logic              last_pass;
    logic              accept;

    shift_step_calc u_step (
        .rem       (rem_q),
        .step      (step),
        .last_pass (last_pass)
    );

    always_comb begin
        req_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:    req_ready = 1'b1;
                DONE:    req_ready = rsp_ready;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign accept    = req_valid & req_ready;
    assign sh_in     = data_q;
    assign sh_ctrl   = (state_q == SHIFT) ? step : '0;
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = data_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: ;
            SHIFT: begin
                data_d = sh_out;
                rem_d  = rem_q - AMT_W'(step);
                if (last_pass) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A load overrides the above; DONE reaches here only with rsp_ready set.
        if (accept) begin
            data_d  = req_data;
            rem_d   = req_amt;
            state_d = (req_amt == '0) ? DONE : SHIFT;
`ifdef SHIFT_SEQ_SATURATE_EN
            if (req_amt >= DATA_W_AMT) begin
                data_d  = '0;
                rem_d   = '0;
                state_d = DONE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural barrel shifter.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic [4:0] req_amt;
    logic [7:0] sh_in;
    logic [2:0] sh_ctrl;
    logic [7:0] sh_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sh_out = sh_in >> sh_ctrl;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .sh_in     (sh_in),
        .sh_ctrl   (sh_ctrl),
        .sh_out    (sh_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [4:0] a);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_gone"}, {7'b0, rsp_valid}, 8'h00);
        chk({tag, "_idle"}, {7'b0, busy}, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 8'h00;
        req_amt   = 5'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", {7'b0, req_ready}, 8'h00);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_sh_ctrl", {5'b0, sh_ctrl}, 8'h00);
        chk("rst_sh_in", sh_in, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {7'b0, req_ready}, 8'h01);

        // 1: single pass of 3
        send(8'hB6, 5'd3);
        chk("t1_sh_ctrl", {5'b0, sh_ctrl}, 8'h03);
        chk("t1_sh_in", sh_in, 8'hB6);
        chk("t1_req_ready", {7'b0, req_ready}, 8'h00);
        chk("t1_busy", {7'b0, busy}, 8'h01);
        tick();
        chk("t1_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t1_rsp_data", rsp_data, 8'h16);
        chk("t1_done_ctrl", {5'b0, sh_ctrl}, 8'h00);
        consume("t1");

        // 2: exact max step, then 7+2
        send(8'h80, 5'd7);
        chk("t2a_sh_ctrl", {5'b0, sh_ctrl}, 8'h07);
        tick();
        chk("t2a_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t2a_rsp_data", rsp_data, 8'h01);
        consume("t2a");
        send(8'h80, 5'd9);
        chk("t2b_pass1", {5'b0, sh_ctrl}, 8'h07);
        tick();
        chk("t2b_pass2", {5'b0, sh_ctrl}, 8'h02);
        chk("t2b_not_done", {7'b0, rsp_valid}, 8'h00);
        tick();
        chk("t2b_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t2b_rsp_data", rsp_data, 8'h00);
        consume("t2b");

        // 3: zero amount skips SHIFT
        send(8'h5A, 5'd0);
        chk("t3_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t3_sh_ctrl", {5'b0, sh_ctrl}, 8'h00);
        chk("t3_rsp_data", rsp_data, 8'h5A);

        // 4: backpressure with a pending request, then same-edge handoff
        req_valid = 1'b1;
        req_data  = 8'hF0;
        req_amt   = 5'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_hold_valid", {7'b0, rsp_valid}, 8'h01);
            chk("t4_hold_data", rsp_data, 8'h5A);
            chk("t4_req_ready", {7'b0, req_ready}, 8'h00);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_req_ready_hs", {7'b0, req_ready}, 8'h01);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("t4_new_shift", {5'b0, sh_ctrl}, 8'h04);
        chk("t4_new_sh_in", sh_in, 8'hF0);
        chk("t4_rsp_low", {7'b0, rsp_valid}, 8'h00);
        tick();
        chk("t4_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t4_rsp_data", rsp_data, 8'h0F);
        consume("t4");

        // 5: reset during the third pass of 31
        send(8'hFF, 5'd31);
`ifndef SHIFT_SEQ_SATURATE_EN
        chk("t5_pass1", {5'b0, sh_ctrl}, 8'h07);
        tick();
        tick();
        chk("t5_pass3", {5'b0, sh_ctrl}, 8'h07);
        chk("t5_pass3_data", sh_in, 8'h00);
`endif
        rst = 1'b1;
        tick();
        chk("t5_abort_busy", {7'b0, busy}, 8'h00);
        chk("t5_abort_rsp", {7'b0, rsp_valid}, 8'h00);
        chk("t5_abort_ctrl", {5'b0, sh_ctrl}, 8'h00);
        chk("t5_abort_ready", {7'b0, req_ready}, 8'h00);
        rst = 1'b0;
        tick();
        chk("t5_no_rsp", {7'b0, rsp_valid}, 8'h00);
        send(8'h11, 5'd1);
        chk("t5b_sh_ctrl", {5'b0, sh_ctrl}, 8'h01);
        tick();
        chk("t5b_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t5b_rsp_data", rsp_data, 8'h08);
        consume("t5b");

        // 6: amount past the word width
        send(8'hFF, 5'd20);
`ifdef SHIFT_SEQ_SATURATE_EN
        chk("t6_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("t6_sh_ctrl", {5'b0, sh_ctrl}, 8'h00);
`else
        chk("t6_pass1", {5'b0, sh_ctrl}, 8'h07);
        tick();
        chk("t6_pass2", {5'b0, sh_ctrl}, 8'h07);
        chk("t6_pass2_in", sh_in, 8'h01);
        tick();
        chk("t6_pass3", {5'b0, sh_ctrl}, 8'h06);
        chk("t6_not_done", {7'b0, rsp_valid}, 8'h00);
        tick();
        chk("t6_rsp_valid", {7'b0, rsp_valid}, 8'h01);
`endif
        chk("t6_rsp_data", rsp_data, 8'h00);
        consume("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
